// File: rtl/pe_feeder.sv
// Sequencer that fetches TAPS weight/feature words from two read buffers, shifts them
// into a multiply-accumulate PE and captures the PE's dot product.
module pe_feeder #(
    parameter int TAPS   = 5,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_w,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] if_base,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result_out,
    output logic              w_ren,
    output logic              if_ren,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] w_rdata,
    input  logic [DATA_W-1:0] if_rdata,
    output logic              W_w,
    output logic              IF_w,
    output logic [DATA_W-1:0] W_in,
    output logic [DATA_W-1:0] IF_in,
    input  logic [31:0]       pe_result
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | k=0..TAPS-1 issue reads; k=TAPS drains the last strobe
    // SETTLE | PE holds its final sum; result captured at end of cycle
    // DONE   | done pulse; start here launches the next run directly
    typedef enum logic [1:0] {IDLE, FETCH, SETTLE, DONE} state_t;

    localparam int K_W = $clog2(TAPS + 1);
    localparam logic [K_W-1:0] K_LAST  = K_W'(TAPS - 1);
    localparam logic [K_W-1:0] K_DRAIN = K_W'(TAPS);

    state_t         state, state_nxt;
    logic [K_W-1:0] k;
    logic           load_q;
    logic           w_resident;
    logic           launch;
    logic           load_eff;

    assign load_eff = load_w | ~w_resident;
    assign W_in     = w_rdata;
    assign IF_in    = if_rdata;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (k == K_DRAIN) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            load_q     <= 1'b0;
            w_resident <= 1'b0;
            w_ren      <= 1'b0;
            if_ren     <= 1'b0;
            w_addr     <= '0;
            if_addr    <= '0;
            W_w        <= 1'b0;
            IF_w       <= 1'b0;
            result_out <= '0;
        end else begin
            state <= state_nxt;
            // Read data arrives one cycle after ren, so the strobe is ren delayed.
            W_w   <= w_ren;
            IF_w  <= if_ren;
            if (launch) begin
                k       <= '0;
                load_q  <= load_eff;
                if_ren  <= 1'b1;
                if_addr <= if_base;
                w_ren   <= load_eff;
                if (load_eff) w_addr <= w_base;
            end else if (state == FETCH) begin
                if (k != K_DRAIN) k <= k + 1'b1;
                if (k == K_LAST) begin
                    if_ren <= 1'b0;
                    w_ren  <= 1'b0;
                end else if (k < K_LAST) begin
                    if_addr <= if_addr + 1'b1;
                    if (load_q) w_addr <= w_addr + 1'b1;
                end
            end
            if (state == SETTLE) begin
                result_out <= pe_result;
                if (load_q) w_resident <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: buffer and 5-tap PE models, per-cycle checks of
// strobes, addresses, busy/done and captured results.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_w;
    logic [9:0]  w_base;
    logic [9:0]  if_base;
    logic        busy;
    logic        done;
    logic [31:0] result_out;
    logic        w_ren;
    logic        if_ren;
    logic [9:0]  w_addr;
    logic [9:0]  if_addr;
    logic [7:0]  w_rdata;
    logic [7:0]  if_rdata;
    logic        W_w;
    logic        IF_w;
    logic [7:0]  W_in;
    logic [7:0]  IF_in;
    logic [31:0] pe_result;

    int errors = 0;
    int checks = 0;
    int exp_prev = 0;

    logic signed [7:0] w_mem  [1024];
    logic signed [7:0] if_mem [1024];
    logic signed [7:0] wsh [5];
    logic signed [7:0] fsh [5];
    int pe_acc;

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk(clk), .rst(rst), .start(start), .load_w(load_w),
        .w_base(w_base), .if_base(if_base), .busy(busy), .done(done),
        .result_out(result_out), .w_ren(w_ren), .if_ren(if_ren),
        .w_addr(w_addr), .if_addr(if_addr), .w_rdata(w_rdata), .if_rdata(if_rdata),
        .W_w(W_w), .IF_w(IF_w), .W_in(W_in), .IF_in(IF_in), .pe_result(pe_result)
    );

    always @(posedge clk) begin
        if (w_ren)  w_rdata  <= w_mem[w_addr];
        if (if_ren) if_rdata <= if_mem[if_addr];
        if (W_w) begin
            for (int i = 4; i > 0; i--) wsh[i] <= wsh[i-1];
            wsh[0] <= W_in;
        end
        if (IF_w) begin
            for (int i = 4; i > 0; i--) fsh[i] <= fsh[i-1];
            fsh[0] <= IF_in;
        end
    end

    always_comb begin
        pe_acc = 0;
        for (int i = 0; i < 5; i++) pe_acc = pe_acc + int'(wsh[i]) * int'(fsh[i]);
        pe_result = pe_acc;
    end

    // Caller raises start at the negedge of cycle T; checks cycles T+1..T+8.
    task automatic do_run(input logic ld_exp, input logic [9:0] wb, input logic [9:0] ifb,
                          input int exp_res);
        logic [5:0] vec, exp_vec;
        logic [9:0] ea;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            vec     = {busy, done, w_ren, if_ren, W_w, IF_w};
            exp_vec = {i <= 7, i == 8, ld_exp && i <= 5, i <= 5,
                       ld_exp && i >= 2 && i <= 6, i >= 2 && i <= 6};
            checks++;
            if (vec !== exp_vec) begin
                errors++;
                $display("FAIL ctl_T+%0d busy/done/w_ren/if_ren/W_w/IF_w got=%b exp=%b", i, vec, exp_vec);
            end
            if (i <= 5) begin
                ea = ifb + 10'(i - 1);
                checks++;
                if (if_addr !== ea) begin
                    errors++;
                    $display("FAIL if_addr_T+%0d got=%0d exp=%0d", i, if_addr, ea);
                end
                if (ld_exp) begin
                    ea = wb + 10'(i - 1);
                    checks++;
                    if (w_addr !== ea) begin
                        errors++;
                        $display("FAIL w_addr_T+%0d got=%0d exp=%0d", i, w_addr, ea);
                    end
                end
            end
            checks++;
            if (i < 8) begin
                if (result_out !== 32'(exp_prev)) begin
                    errors++;
                    $display("FAIL result_hold_T+%0d got=%0d exp=%0d", i, $signed(result_out), exp_prev);
                end
            end else if (result_out !== 32'(exp_res)) begin
                errors++;
                $display("FAIL result_T+8 got=%0d exp=%0d", $signed(result_out), exp_res);
            end
        end
        exp_prev = exp_res;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; load_w = 1'b1; w_base = 10'd0; if_base = 10'd16;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, w_ren, if_ren, W_w, IF_w} !== 6'b0 || result_out !== 32'd0 ||
            w_addr !== 10'd0 || if_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b res=%0d wa=%0d ia=%0d exp all 0",
                     {busy, done, w_ren, if_ren, W_w, IF_w}, result_out, w_addr, if_addr);
        end
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, w_ren, if_ren, W_w, IF_w} !== 6'b0) begin
                errors++;
                $display("FAIL reset_quiet_%0d got=%b exp=000000", i, {busy, done, w_ren, if_ren, W_w, IF_w});
            end
        end
    endtask

    task automatic test_forced_load;
        load_w = 1'b0; w_base = 10'd0; if_base = 10'd16; start = 1'b1;
        do_run(1'b1, 10'd0, 10'd16, 55);
    endtask

    task automatic test_basic;
        load_w = 1'b1; w_base = 10'd0; if_base = 10'd16; start = 1'b1;
        do_run(1'b1, 10'd0, 10'd16, 55);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_reuse;
        load_w = 1'b0; w_base = 10'd500; if_base = 10'd32; start = 1'b1;
        do_run(1'b0, 10'd500, 10'd32, -15);
    endtask

    task automatic test_wrap;
        load_w = 1'b1; w_base = 10'd100; if_base = 10'd1022; start = 1'b1;
        do_run(1'b1, 10'd100, 10'd1022, 81920);
    endtask

    task automatic test_back_to_back;
        load_w = 1'b1; w_base = 10'd0; if_base = 10'd16; start = 1'b1;
        do_run(1'b1, 10'd0, 10'd16, 55);
        load_w = 1'b0; if_base = 10'd32; start = 1'b1;
        do_run(1'b0, 10'd0, 10'd32, -15);
    endtask

    task automatic test_abort;
        load_w = 1'b1; w_base = 10'd0; if_base = 10'd16; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) start = 1'b1;
            if (i == 4) begin
                start = 1'b0;
                checks++;
                if (if_addr !== 10'd19 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ignore_start got if_addr=%0d busy=%b exp 19 1", if_addr, busy);
                end
                rst = 1'b0;
            end
            if (i == 5) begin
                rst = 1'b1;
                checks++;
                if ({busy, done, w_ren, if_ren, W_w, IF_w} !== 6'b0 || result_out !== 32'd0 ||
                    if_addr !== 10'd0) begin
                    errors++;
                    $display("FAIL abort_reset got ctl=%b res=%0d ia=%0d exp 0",
                             {busy, done, w_ren, if_ren, W_w, IF_w}, result_out, if_addr);
                end
            end
        end
        exp_prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done_%0d got done=%b busy=%b exp 0 0", i, done, busy);
            end
        end
        load_w = 1'b0; w_base = 10'd0; if_base = 10'd16; start = 1'b1;
        do_run(1'b1, 10'd0, 10'd16, 55);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            w_mem[i]  = 8'sd0;
            if_mem[i] = 8'sd0;
        end
        for (int i = 0; i < 5; i++) begin
            w_mem[i]        = 8'(i + 1);
            if_mem[16 + i]  = 8'(i + 1);
            if_mem[32 + i]  = -8'sd1;
            w_mem[100 + i]  = -8'sd128;
            if_mem[(1022 + i) % 1024] = -8'sd128;
        end
        rst = 1'b0; start = 1'b0; load_w = 1'b0; w_base = '0; if_base = '0;
        @(negedge clk);
        test_reset;
        test_forced_load;
        test_basic;
        test_reuse;
        test_wrap;
        test_back_to_back;
        test_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
